// File: rtl/shreg_pkg.sv
// Shared types for the universal shift register: operation encoding and control FSM states.
package shreg_pkg;

  typedef enum logic [1:0] {
    SHREG_HOLD = 2'd0,
    SHREG_SHL  = 2'd1,
    SHREG_SHR  = 2'd2,
    SHREG_LOAD = 2'd3
  } shreg_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } shreg_state_e;

endpackage

// File: rtl/shreg_ctr.sv
// Loadable shift-length down-counter; lengths above WIDTH are clamped, last flags count==1.
module shreg_ctr
  import shreg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] len,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  logic [CNT_W-1:0] clamp_s;

  // clamp the requested length to the register width
  always_comb begin
    clamp_s = len;
    if (len > MAX_CNT) begin
      clamp_s = MAX_CNT;
    end else begin
      clamp_s = len;
    end
  end

  // counter register: load at start, count down on each shift
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= {CNT_W{1'b0}};
    end else if (load) begin
      count <= clamp_s;
    end else if (dec && (count != {CNT_W{1'b0}})) begin
      count <= count - ONE_CNT;
    end else begin
      count <= count;
    end
  end

  assign last = (count == ONE_CNT);

endmodule

// File: rtl/shreg_univ.sv
// Universal shift register: parallel load, counted left/right shifts, serial and parallel outputs.
// Rotate support (rot port) is compiled in when SHREG_ROTATE_EN is defined.
module shreg_univ
  import shreg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] len,
  input  logic             sin,
  input  logic [WIDTH-1:0] pin,
`ifdef SHREG_ROTATE_EN
  input  logic             rot,
`endif
  output logic [WIDTH-1:0] pout,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  shreg_state_e     state_r;
  shreg_mode_e      mode_s;
  logic             dir_r;
  logic             start_s;
  logic             shift_s;
  logic             last_s;
  logic             zero_s;
  logic [CNT_W-1:0] count_s;
  logic [CNT_W-1:0] len_ld_s;
  logic             in_l_s;
  logic             in_r_s;
`ifdef SHREG_ROTATE_EN
  logic             rot_r;
`endif

  assign mode_s  = shreg_mode_e'(mode);
  assign start_s = (state_r == ST_IDLE) && go;
  assign zero_s  = (count_s == {CNT_W{1'b0}});
  // non-shift operations spend one settle cycle in SHIFT with a zero count
  assign shift_s = (state_r == ST_SHIFT) && !zero_s;

`ifdef SHREG_ROTATE_EN
  assign in_l_s = rot_r ? pout[WIDTH-1] : sin;
  assign in_r_s = rot_r ? pout[0] : sin;
`else
  assign in_l_s = sin;
  assign in_r_s = sin;
`endif

  // only shift operations carry a length into the counter
  always_comb begin
    len_ld_s = {CNT_W{1'b0}};
    case (mode_s)
      SHREG_SHL, SHREG_SHR: len_ld_s = len;
      default:              len_ld_s = {CNT_W{1'b0}};
    endcase
  end

  shreg_ctr #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_ctr (
    .clk   (clk),
    .reset (reset),
    .load  (start_s),
    .dec   (shift_s),
    .len   (len_ld_s),
    .count (count_s),
    .last  (last_s)
  );

  // control FSM and datapath with registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      pout    <= {WIDTH{1'b0}};
      sout    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      dir_r   <= 1'b0;
`ifdef SHREG_ROTATE_EN
      rot_r   <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          done <= 1'b0;
          if (go) begin
            state_r <= ST_SHIFT;
            busy    <= 1'b1;
            dir_r   <= (mode_s == SHREG_SHR);
`ifdef SHREG_ROTATE_EN
            rot_r   <= rot;
`endif
            if (mode_s == SHREG_LOAD) begin
              pout <= pin;
            end else begin
              pout <= pout;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (shift_s) begin
            if (dir_r) begin
              sout <= pout[0];
              pout <= {in_r_s, pout[WIDTH-1:1]};
            end else begin
              sout <= pout[WIDTH-1];
              pout <= {pout[WIDTH-2:0], in_l_s};
            end
          end else begin
            sout <= sout;
          end
          if (last_s || zero_s) begin
            state_r <= ST_DONE;
            done    <= 1'b1;
          end else begin
            state_r <= ST_SHIFT;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shreg_univ.sv
// Scoreboard bench for shreg_univ (WIDTH=8): per-cycle expected {pout,sout,busy,done} queued at stimulus time.
module tb_shreg_univ;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk   = 1'b0;
  logic             reset = 1'b0;
  logic             go    = 1'b0;
  logic             sin   = 1'b0;
  logic [1:0]       mode  = 2'd0;
  logic [CNT_W-1:0] len   = 4'd0;
  logic [WIDTH-1:0] pin   = 8'h00;
`ifdef SHREG_ROTATE_EN
  logic             rot   = 1'b0;
`endif
  logic [WIDTH-1:0] pout;
  logic             sout;
  logic             busy;
  logic             done;

  int total = 0;
  int bad   = 0;

  logic [WIDTH+2:0] sb_q[$];
  logic [WIDTH+2:0] exp_v;
  logic [WIDTH-1:0] m_pout = 8'h00;
  logic             m_sout = 1'b0;

  always #5 clk = ~clk;

  shreg_univ #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .go    (go),
    .mode  (mode),
    .len   (len),
    .sin   (sin),
    .pin   (pin),
`ifdef SHREG_ROTATE_EN
    .rot   (rot),
`endif
    .pout  (pout),
    .sout  (sout),
    .busy  (busy),
    .done  (done)
  );

  // Drive one operation (go asserted) and queue the expected output after every following edge.
  task automatic start_op(input logic [1:0] md, input int ln, input logic s, input logic r,
                          input logic [WIDTH-1:0] p);
    int   n;
    logic ob;
    mode = md;
    len  = CNT_W'(ln);
    sin  = s;
    pin  = p;
    go   = 1'b1;
`ifdef SHREG_ROTATE_EN
    rot  = r;
`endif
    if (md == 2'd3) m_pout = p;
    sb_q.push_back({m_pout, m_sout, 1'b1, 1'b0});
    n = (md == 2'd1 || md == 2'd2) ? ((ln > WIDTH) ? WIDTH : ln) : 0;
    if (n == 0) sb_q.push_back({m_pout, m_sout, 1'b1, 1'b1});
    for (int k = 1; k <= n; k++) begin
      if (md == 2'd1) begin
        ob     = m_pout[WIDTH-1];
        m_pout = {m_pout[WIDTH-2:0], (r ? ob : s)};
      end else begin
        ob     = m_pout[0];
        m_pout = {(r ? ob : s), m_pout[WIDTH-1:1]};
      end
      m_sout = ob;
      sb_q.push_back({m_pout, m_sout, 1'b1, (k == n)});
    end
    sb_q.push_back({m_pout, m_sout, 1'b0, 1'b0});
  endtask

  task automatic test_reset;
    #12;
    total++;
    if ({pout, sout, busy, done} !== 11'h000) begin
      bad++;
      $display("FAIL reset: got %h want %h", {pout, sout, busy, done}, 11'h000);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_load(input logic [WIDTH-1:0] p);
    start_op(2'd3, 0, 1'b0, 1'b0, p);
    while (sb_q.size() > 0) begin
      @(posedge clk); @(negedge clk);
      go = 1'b0;
      exp_v = sb_q.pop_front();
      total++;
      if ({pout, sout, busy, done} !== exp_v) begin
        bad++;
        $display("FAIL load: got %h want %h", {pout, sout, busy, done}, exp_v);
      end
    end
  endtask

  task automatic test_shl;
    start_op(2'd1, 3, 1'b1, 1'b0, 8'h00);
    while (sb_q.size() > 0) begin
      @(posedge clk); @(negedge clk);
      go = 1'b0;
      exp_v = sb_q.pop_front();
      total++;
      if ({pout, sout, busy, done} !== exp_v) begin
        bad++;
        $display("FAIL shl: got %h want %h", {pout, sout, busy, done}, exp_v);
      end
    end
    total++;
    if (pout !== 8'h2F || sout !== 1'b1) begin
      bad++;
      $display("FAIL shl_final: got pout=%h sout=%b want pout=2f sout=1", pout, sout);
    end
  endtask

  task automatic test_shr_ignore_go;
    int c;
    c = 0;
    start_op(2'd2, 8, 1'b0, 1'b0, 8'h00);
    while (sb_q.size() > 0) begin
      @(posedge clk); @(negedge clk);
      c++;
      // stray go/mode/len during the shift must be ignored
      go   = (c >= 3 && c <= 6);
      mode = (c >= 3 && c <= 6) ? 2'd3 : 2'd2;
      len  = 4'd1;
      pin  = 8'hFF;
      exp_v = sb_q.pop_front();
      total++;
      if ({pout, sout, busy, done} !== exp_v) begin
        bad++;
        $display("FAIL shr cyc%0d: got %h want %h", c, {pout, sout, busy, done}, exp_v);
      end
    end
    total++;
    if (pout !== 8'h00) begin
      bad++;
      $display("FAIL shr_final: got %h want 00", pout);
    end
  endtask

  task automatic test_len(input logic [1:0] md, input int ln, input logic s);
    start_op(md, ln, s, 1'b0, 8'h00);
    while (sb_q.size() > 0) begin
      @(posedge clk); @(negedge clk);
      go = 1'b0;
      exp_v = sb_q.pop_front();
      total++;
      if ({pout, sout, busy, done} !== exp_v) begin
        bad++;
        $display("FAIL len%0d mode%0d: got %h want %h", ln, md, {pout, sout, busy, done}, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid;
    start_op(2'd2, 8, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      go = 1'b0;
      exp_v = sb_q.pop_front();
      total++;
      if ({pout, sout, busy, done} !== exp_v) begin
        bad++;
        $display("FAIL rst_pre%0d: got %h want %h", i, {pout, sout, busy, done}, exp_v);
      end
    end
    reset = 1'b0;
    #1;
    total++;
    if ({pout, sout, busy, done} !== 11'h000) begin
      bad++;
      $display("FAIL rst_async: got %h want %h", {pout, sout, busy, done}, 11'h000);
    end
    sb_q.delete();
    m_pout = 8'h00;
    m_sout = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      total++;
      if ({pout, sout, busy, done} !== 11'h000) begin
        bad++;
        $display("FAIL rst_hold%0d: got %h want %h", i, {pout, sout, busy, done}, 11'h000);
      end
    end
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); @(negedge clk);
      total++;
      if ({pout, sout, busy, done} !== 11'h000) begin
        bad++;
        $display("FAIL rst_idle%0d: got %h want %h", i, {pout, sout, busy, done}, 11'h000);
      end
    end
  endtask

`ifdef SHREG_ROTATE_EN
  task automatic test_rotate;
    start_op(2'd2, 4, 1'b0, 1'b1, 8'h00);
    while (sb_q.size() > 0) begin
      @(posedge clk); @(negedge clk);
      go  = 1'b0;
      rot = 1'b0;
      exp_v = sb_q.pop_front();
      total++;
      if ({pout, sout, busy, done} !== exp_v) begin
        bad++;
        $display("FAIL rot: got %h want %h", {pout, sout, busy, done}, exp_v);
      end
    end
    total++;
    if (pout !== 8'h5A) begin
      bad++;
      $display("FAIL rot_final: got %h want 5a", pout);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load(8'hA5);
    test_shl();
    test_load(8'hA5);
    test_shr_ignore_go();
    test_load(8'h3C);
    test_len(2'd1, 12, 1'b1);
    test_len(2'd2, 0, 1'b1);
    test_len(2'd1, 0, 1'b0);
    test_len(2'd0, 5, 1'b1);
    test_len(2'd2, 5, 1'b1);
    test_len(2'd1, 1, 1'b0);
    test_load(8'hFF);
    test_reset_mid();
`ifdef SHREG_ROTATE_EN
    test_load(8'hA5);
    test_rotate();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
